icache_assoc: RTL and testbench
===============================

ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 8: ways, power of two, 2..16.
REQ-002 SHALL have parameter WORDS_PER_BLOCK, default 4: 32-bit words per line, one of 1, 2, 4, 8.
REQ-003 SHALL have parameter REPL_MODE, default 0: 0 = pure FIFO victim; 1 = lowest-index invalid way first, else FIFO.
REQ-004 SHALL have CLK  input  1  clock, rising edge.
REQ-005 SHALL have RESET  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have PC  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 SHALL have REQ_VALID  input  1  fetch request, sampled in IDLE.
REQ-008 SHALL have FLUSH  input  1  invalidate-all request.
REQ-009 SHALL have HIT  output  1  data valid / PCWrite-IFIDWrite enable, one-cycle pulse.
REQ-010 SHALL have DATA_OUT  output  32  instruction word, valid when HIT=1.
REQ-011 SHALL have MM_REQ  output  1  main-memory read request, held until MM_ACK.
REQ-012 SHALL have MM_ADDR  output  32  word address of the current refill beat, bits [1:0]=0.
REQ-013 SHALL have MM_ACK  input  1  MM_DATA valid; completes one beat.
REQ-014 SHALL have MM_DATA  input  32  refill word.
REQ-015 SHALL have BUSY  output  1  high in every state except IDLE.
REQ-016 SHALL have CNT_HIT, CNT_MISS  output  20 each  event counters.

Function
REQ-017 Offset = PC[OB+1:2], OB = log2(WORDS_PER_BLOCK); tag = PC[31:OB+2]; no index field (fully associative).
REQ-018 FSM states: IDLE, LOOKUP, FILL, RESPOND.
REQ-019 IDLE: REQ_VALID=1 and FLUSH=0 -> capture PC, go to LOOKUP.
REQ-020 LOOKUP, hit (valid and tag equal): HIT=1, DATA_OUT=stored word at offset, CNT_HIT+1, return to IDLE; request-to-HIT latency 2 cycles.
REQ-021 Multiple matching ways SHALL resolve to the lowest index.
REQ-022 LOOKUP, miss: HIT=0, DATA_OUT=0, CNT_MISS+1, select victim per REPL_MODE, clear the victim's valid bit, go to FILL.
REQ-023 FILL: MM_REQ=1, MM_ADDR = {tag, beat, 2'b00}, beats 0..WORDS_PER_BLOCK-1 in order; each MM_ACK writes MM_DATA into the victim and advances beat.
REQ-024 After the final ACK: set victim valid, write tag, advance FIFO pointer (mod NUM_WAYS, wraps NUM_WAYS-1 -> 0), go to RESPOND.
REQ-025 The FIFO pointer SHALL advance only on a fill using the FIFO victim, not when REPL_MODE=1 selects an invalid way.
REQ-026 RESPOND: HIT=1, DATA_OUT = requested word (forwarded from line), return to IDLE; counters unchanged.
REQ-027 MM_ACK outside FILL SHALL be ignored.
REQ-028 FLUSH in IDLE: clear all valid bits and FIFO pointer in one cycle; takes priority over simultaneous REQ_VALID, which is dropped.
REQ-029 FLUSH outside IDLE SHALL be latched as pending and executed upon the next entry to IDLE, before any new request.
REQ-030 Counters SHALL wrap at 2^20.
REQ-031 HIT, MM_REQ SHALL be 0 and DATA_OUT SHALL hold 0 in IDLE.

Reset
REQ-032 RESET: state=IDLE, all valid bits 0, FIFO pointer 0, pending flush 0, HIT=0, DATA_OUT=0, MM_REQ=0, MM_ADDR=0, BUSY=0, CNT_HIT=0, CNT_MISS=0.
REQ-033 RESET mid-FILL SHALL abandon the refill; the victim stays invalid and MM_REQ drops immediately.
REQ-034 Tag/data storage SHALL NOT require reset.

Configuration
REQ-035 Macro ICACHE_STATS_EN defined: CNT_HIT/CNT_MISS counters implemented per REQ-020/022/030.
REQ-036 Macro ICACHE_STATS_EN undefined: no counter registers; CNT_HIT and CNT_MISS SHALL be constant 0.

Verification
REQ-037 Reset; REQ_VALID with PC=0x100, WPB=4, MM_ACK one cycle after MM_REQ -> MM_ADDR 0x100,0x104,0x108,0x10C; HIT pulse with beat-0 data; CNT_MISS=1.
REQ-038 Then PC=0x108 -> HIT two cycles after REQ_VALID, DATA_OUT=beat-2 word, CNT_HIT=1, no MM_REQ.
REQ-039 Nine distinct-block misses, REPL_MODE=0, NUM_WAYS=8 -> ninth fill replaces way 0; first block re-fetch misses.
REQ-040 REPL_MODE=1: fill ways 0..2, FLUSH, miss -> refill targets way 0; FLUSH asserted with REQ_VALID in IDLE -> request dropped, all lines invalid.
REQ-041 RESET asserted during FILL beat 2 -> MM_REQ=0 same cycle; after release, same PC misses; MM_ACK stalled 5 cycles -> MM_REQ and MM_ADDR held stable.
REQ-042 Build without ICACHE_STATS_EN; run REQ-037 -> CNT_HIT=CNT_MISS=0, HIT/DATA_OUT identical.

Source files
------------

// File: rtl/icache_assoc_if.sv
// rtl/icache_assoc_if.sv - main-memory refill bus between icache_assoc and its backing store
// The cache drives the read request and beat address; memory returns one word per MM_ACK.
interface icache_assoc_if;
  logic        MM_REQ;
  logic [31:0] MM_ADDR;
  logic        MM_ACK;
  logic [31:0] MM_DATA;

  modport master (output MM_REQ, MM_ADDR, input MM_ACK, MM_DATA);
  modport slave  (input MM_REQ, MM_ADDR, output MM_ACK, MM_DATA);
endinterface

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - fully associative instruction cache with FIFO/invalid-first replacement
// Define ICACHE_STATS_EN to build the CNT_HIT/CNT_MISS event counters; otherwise they read 0.
module icache_assoc #(
  parameter int NUM_WAYS        = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int REPL_MODE       = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC,
  input  logic        REQ_VALID,
  input  logic        FLUSH,
  output logic        HIT,
  output logic [31:0] DATA_OUT,
  output logic        BUSY,
  output logic [19:0] CNT_HIT,
  output logic [19:0] CNT_MISS,
  icache_assoc_if.master mm
);
  localparam int OB  = $clog2(WORDS_PER_BLOCK);
  localparam int OBW = (OB == 0) ? 1 : OB;
  localparam int TW  = 30 - OB;
  localparam int WW  = $clog2(NUM_WAYS);

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESPOND} state_t;

  state_t              state;
  logic [NUM_WAYS-1:0] valid;
  logic [WW-1:0]       fifo_ptr, victim, hit_way, inv_way, sel_way;
  logic                hit_any, inv_any, use_inv, fill_fifo, flush_pend, flush_now, last_beat;
  logic [TW-1:0]       req_tag, pc_tag;
  logic [OBW-1:0]      req_off, pc_off, beat;
  logic [TW-1:0]       tag_mem  [NUM_WAYS];
  logic [31:0]         data_mem [NUM_WAYS][WORDS_PER_BLOCK];

  assign pc_tag    = PC[31:OB+2];
  assign pc_off    = OBW'((PC >> 2) & 32'(WORDS_PER_BLOCK - 1));
  assign last_beat = (beat == OBW'(WORDS_PER_BLOCK - 1));
  assign use_inv   = (REPL_MODE == 1) && inv_any;
  assign sel_way   = use_inv ? inv_way : fifo_ptr;
  assign flush_now = flush_pend | FLUSH;

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid[w] && tag_mem[w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid[w]) begin
        inv_any = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      valid       <= '0;
      fifo_ptr    <= '0;
      flush_pend  <= 1'b0;
      victim      <= '0;
      fill_fifo   <= 1'b0;
      req_tag     <= '0;
      req_off     <= '0;
      beat        <= '0;
      HIT         <= 1'b0;
      DATA_OUT    <= '0;
      BUSY        <= 1'b0;
      mm.MM_REQ   <= 1'b0;
      mm.MM_ADDR  <= '0;
    end else begin
      case (state)
        IDLE: begin
          HIT      <= 1'b0;
          DATA_OUT <= '0;
          if (FLUSH) begin
            valid    <= '0;
            fifo_ptr <= '0;
          end else if (REQ_VALID) begin
            req_tag <= pc_tag;
            req_off <= pc_off;
            BUSY    <= 1'b1;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          flush_pend <= flush_now;
          if (hit_any) begin
            HIT      <= 1'b1;
            DATA_OUT <= data_mem[hit_way][req_off];
            BUSY     <= 1'b0;
            state    <= IDLE;
            if (flush_now) begin
              valid      <= '0;
              fifo_ptr   <= '0;
              flush_pend <= 1'b0;
            end
          end else begin
            victim         <= sel_way;
            fill_fifo      <= !use_inv;
            valid[sel_way] <= 1'b0;
            beat           <= '0;
            mm.MM_REQ      <= 1'b1;
            mm.MM_ADDR     <= {req_tag, {(OB + 2){1'b0}}};
            state          <= FILL;
          end
        end
        FILL: begin
          flush_pend <= flush_now;
          if (mm.MM_ACK) begin
            if (last_beat) begin
              mm.MM_REQ     <= 1'b0;
              valid[victim] <= 1'b1;
              if (fill_fifo)
                fifo_ptr <= fifo_ptr + WW'(1);
              state <= RESPOND;
            end else begin
              beat       <= beat + OBW'(1);
              mm.MM_ADDR <= {req_tag, {(OB + 2){1'b0}}} | (32'(beat + OBW'(1)) << 2);
            end
          end
        end
        RESPOND: begin
          HIT        <= 1'b1;
          DATA_OUT   <= data_mem[victim][req_off];
          BUSY       <= 1'b0;
          state      <= IDLE;
          flush_pend <= 1'b0;
          // A flush seen while busy lands here, before IDLE can accept a new fetch.
          if (flush_now) begin
            valid    <= '0;
            fifo_ptr <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (state == FILL && mm.MM_ACK) begin
      data_mem[victim][beat] <= mm.MM_DATA;
      if (last_beat)
        tag_mem[victim] <= req_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [19:0] cnt_hit_q, cnt_miss_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_hit_q  <= '0;
      cnt_miss_q <= '0;
    end else if (state == LOOKUP) begin
      if (hit_any)
        cnt_hit_q <= cnt_hit_q + 20'd1;
      else
        cnt_miss_q <= cnt_miss_q + 20'd1;
    end
  end

  assign CNT_HIT  = cnt_hit_q;
  assign CNT_MISS = cnt_miss_q;
`else
  assign CNT_HIT  = '0;
  assign CNT_MISS = '0;
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - scoreboard bench for icache_assoc, FIFO and invalid-first builds side by side
// Memory returns ~address for every word, so the expected fetch word is ~{PC[31:2],2'b00}.
module tb_icache_assoc;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PC;
  logic        REQ_VALID, FLUSH;
  logic        hit0, hit1, busy0, busy1;
  logic [31:0] dout0, dout1;
  logic [19:0] ch0, cm0, ch1, cm1;

  icache_assoc_if mm0 ();
  icache_assoc_if mm1 ();

  icache_assoc #(.NUM_WAYS(8), .WORDS_PER_BLOCK(4), .REPL_MODE(0)) u0 (
    .CLK(CLK), .RESET(RESET), .PC(PC), .REQ_VALID(REQ_VALID), .FLUSH(FLUSH),
    .HIT(hit0), .DATA_OUT(dout0), .BUSY(busy0), .CNT_HIT(ch0), .CNT_MISS(cm0), .mm(mm0));

  icache_assoc #(.NUM_WAYS(8), .WORDS_PER_BLOCK(4), .REPL_MODE(1)) u1 (
    .CLK(CLK), .RESET(RESET), .PC(PC), .REQ_VALID(REQ_VALID), .FLUSH(FLUSH),
    .HIT(hit1), .DATA_OUT(dout1), .BUSY(busy1), .CNT_HIT(ch1), .CNT_MISS(cm1), .mm(mm1));

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  int          exp_hit = 0;
  int          exp_miss = 0;
  logic [32:0] exp0 [$];
  logic [32:0] exp1 [$];
  logic [31:0] log0 [$];

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  // Memory model for the FIFO build; also checks the request is held while acks are stalled.
  initial begin : mem0
    int w;
    logic [31:0] held;
    w = 0;
    held = '0;
    mm0.MM_ACK = 1'b0;
    mm0.MM_DATA = '0;
    forever begin
      @(negedge CLK);
      if (RESET || mm0.MM_ACK) begin
        mm0.MM_ACK = 1'b0;
        w = 0;
      end else if (mm0.MM_REQ) begin
        if (w == 0) held = mm0.MM_ADDR;
        else chk(mm0.MM_ADDR === held, "mm_addr_hold", mm0.MM_ADDR, held);
        if (w >= ack_delay) begin
          mm0.MM_ACK  = 1'b1;
          mm0.MM_DATA = ~mm0.MM_ADDR;
          log0.push_back(mm0.MM_ADDR);
          w = 0;
        end else w++;
      end else if (w != 0) begin
        chk(mm0.MM_REQ === 1'b1, "mm_req_hold", 32'(mm0.MM_REQ), 32'd1);
        w = 0;
      end
    end
  end

  initial begin : mem1
    int w;
    w = 0;
    mm1.MM_ACK = 1'b0;
    mm1.MM_DATA = '0;
    forever begin
      @(negedge CLK);
      if (RESET || mm1.MM_ACK) begin
        mm1.MM_ACK = 1'b0;
        w = 0;
      end else if (mm1.MM_REQ) begin
        if (w >= ack_delay) begin
          mm1.MM_ACK  = 1'b1;
          mm1.MM_DATA = ~mm1.MM_ADDR;
          w = 0;
        end else w++;
      end
    end
  end

  // Monitor: every HIT pulse pops one expectation {refill_seen, word} per build.
  initial begin : monitor
    logic [32:0] e;
    bit f0, f1;
    f0 = 1'b0;
    f1 = 1'b0;
    forever begin
      @(negedge CLK);
      if (hit0) begin
        chk(exp0.size() != 0, "hit0_expected", 32'(exp0.size()), 32'd1);
        if (exp0.size() != 0) begin
          e = exp0.pop_front();
          chk(dout0 === e[31:0], "data0", dout0, e[31:0]);
          chk(f0 === e[32], "refill0", 32'(f0), 32'(e[32]));
        end
        f0 = 1'b0;
      end else if (mm0.MM_REQ) f0 = 1'b1;
      if (hit1) begin
        chk(exp1.size() != 0, "hit1_expected", 32'(exp1.size()), 32'd1);
        if (exp1.size() != 0) begin
          e = exp1.pop_front();
          chk(dout1 === e[31:0], "data1", dout1, e[31:0]);
          chk(f1 === e[32], "refill1", 32'(f1), 32'(e[32]));
        end
        f1 = 1'b0;
      end else if (mm1.MM_REQ) f1 = 1'b1;
      if (RESET) begin
        f0 = 1'b0;
        f1 = 1'b0;
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, input bit miss, input bit flush_mid);
    int n;
    bit got;
    logic [31:0] word;
    word = ~{pc[31:2], 2'b00};
    PC = pc;
    REQ_VALID = 1'b1;
    exp0.push_back({miss, word});
    exp1.push_back({miss, word});
    if (miss) exp_miss++; else exp_hit++;
    n = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge CLK);
      n++;
      if (n == 1) REQ_VALID = 1'b0;
      if (flush_mid) FLUSH = (n == 2);
      if (hit0) got = 1'b1;
    end
    FLUSH = 1'b0;
    chk(got, "hit_timeout", 32'(n), 32'd300);
    if (got && !miss) chk(n == 2, "hit_latency", 32'(n), 32'd2);
  endtask

  task automatic do_flush();
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
  endtask

  task automatic check_cnt(input string tag);
    logic [19:0] eh, em;
    eh = STATS ? 20'(exp_hit) : 20'd0;
    em = STATS ? 20'(exp_miss) : 20'd0;
    chk(ch0 === eh, {tag, "_cnt_hit0"}, 32'(ch0), 32'(eh));
    chk(cm0 === em, {tag, "_cnt_miss0"}, 32'(cm0), 32'(em));
    chk(ch1 === eh, {tag, "_cnt_hit1"}, 32'(ch1), 32'(eh));
    chk(cm1 === em, {tag, "_cnt_miss1"}, 32'(cm1), 32'(em));
  endtask

  initial begin : watchdog
    #400000;
    chk(1'b0, "watchdog", 32'(checks), 32'd0);
    summary();
    $finish;
  end

  initial begin : stim
    int n;
    logic [31:0] beats [4];
    RESET = 1'b1;
    PC = '0;
    REQ_VALID = 1'b0;
    FLUSH = 1'b0;
    repeat (2) @(negedge CLK);
    chk(hit0 === 1'b0, "rst_hit", 32'(hit0), 32'd0);
    chk(dout0 === 32'd0, "rst_data", dout0, 32'd0);
    chk(mm0.MM_REQ === 1'b0, "rst_mm_req", 32'(mm0.MM_REQ), 32'd0);
    chk(mm0.MM_ADDR === 32'd0, "rst_mm_addr", mm0.MM_ADDR, 32'd0);
    chk(busy0 === 1'b0, "rst_busy", 32'(busy0), 32'd0);
    chk(ch0 === 20'd0 && cm0 === 20'd0, "rst_counters", {12'd0, ch0 | cm0}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Cold miss on 0x100: four beats in address order, then the beat-0 word.
    fetch(32'h100, 1'b1, 1'b0);
    beats = '{32'h100, 32'h104, 32'h108, 32'h10C};
    chk(log0.size() == 4, "beat_count", 32'(log0.size()), 32'd4);
    for (int i = 0; i < 4 && i < log0.size(); i++)
      chk(log0[i] === beats[i], "beat_addr", log0[i], beats[i]);
    check_cnt("first_miss");

    fetch(32'h108, 1'b0, 1'b0);
    check_cnt("first_hit");
    @(negedge CLK);
    chk(hit0 === 1'b0, "hit_pulse_width", 32'(hit0), 32'd0);
    chk(dout0 === 32'd0, "idle_data_zero", dout0, 32'd0);
    chk(busy0 === 1'b0, "idle_busy", 32'(busy0), 32'd0);

    // Nine distinct blocks into eight ways: the ninth evicts the first.
    do_flush();
    for (int i = 0; i < 9; i++) fetch(32'h2000 + 32'(i) * 32'h10, 1'b1, 1'b0);
    fetch(32'h2014, 1'b0, 1'b0);
    fetch(32'h2000, 1'b1, 1'b0);
    fetch(32'h208C, 1'b0, 1'b0);

    // Flush together with a request: request dropped, every line invalid.
    PC = 32'h2080;
    REQ_VALID = 1'b1;
    FLUSH = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    FLUSH = 1'b0;
    chk(busy0 === 1'b0, "flush_drops_req", 32'(busy0), 32'd0);
    repeat (4) @(negedge CLK);
    fetch(32'h2080, 1'b1, 1'b0);

    // Fill three ways, flush, and the refill goes back into way 0.
    do_flush();
    fetch(32'h3000, 1'b1, 1'b0);
    fetch(32'h3010, 1'b1, 1'b0);
    fetch(32'h3020, 1'b1, 1'b0);
    do_flush();
    fetch(32'h3018, 1'b1, 1'b0);
    fetch(32'h3010, 1'b0, 1'b0);
    fetch(32'h3020, 1'b1, 1'b0);

    // Flush during a refill is deferred until the fetch has been answered.
    fetch(32'h4000, 1'b1, 1'b1);
    fetch(32'h4004, 1'b1, 1'b0);
    check_cnt("mid");

    // Stalled memory: five idle cycles per beat, request must stay put.
    ack_delay = 5;
    fetch(32'h5004, 1'b1, 1'b0);
    ack_delay = 0;

    // Reset while beat 2 is on the bus.
    log0.delete();
    PC = 32'h6000;
    REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    n = 0;
    while (log0.size() < 3 && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk(log0.size() == 3, "reach_beat2", 32'(log0.size()), 32'd3);
    if (log0.size() == 3) chk(log0[2] === 32'h6008, "beat2_addr", log0[2], 32'h6008);
    #1 RESET = 1'b1;
    #1;
    chk(mm0.MM_REQ === 1'b0, "rst_drops_req0", 32'(mm0.MM_REQ), 32'd0);
    chk(mm1.MM_REQ === 1'b0, "rst_drops_req1", 32'(mm1.MM_REQ), 32'd0);
    chk(busy0 === 1'b0, "rst_busy_fill", 32'(busy0), 32'd0);
    exp_hit = 0;
    exp_miss = 0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    fetch(32'h6000, 1'b1, 1'b0);
    check_cnt("after_reset");

    repeat (3) @(negedge CLK);
    chk(exp0.size() == 0, "scoreboard0_drained", 32'(exp0.size()), 32'd0);
    chk(exp1.size() == 0, "scoreboard1_drained", 32'(exp1.size()), 32'd0);
    summary();
    $finish;
  end
endmodule
